// File: rtl/dm_master.sv
// dm_master: MEM-stage data-memory bus initiator with alignment checks,
// byte-lane steering, load sign extension and a response timeout.
module dm_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  dm_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] op_r;
    logic [1:0] k_r;
    logic is_store, is_load, is_word, is_byte, is_half, accept, misal, hs, tmo;
    logic [3:0] be;
    logic [31:0] wd, ext;
    logic [7:0] rbyte;
    logic [15:0] rhalf;
    always_comb begin
        is_store = dm_op == 3'd1 || dm_op == 3'd2 || dm_op == 3'd3;
        is_load  = dm_op == 3'd4 || dm_op == 3'd5 || dm_op == 3'd6;
        is_word  = dm_op == 3'd1 || dm_op == 3'd4;
        is_byte  = dm_op == 3'd2 || dm_op == 3'd5;
        is_half  = dm_op == 3'd3 || dm_op == 3'd6;
        accept   = state == IDLE && req_valid && (is_store || is_load);
        misal    = is_word ? |addr[1:0] : is_half && addr[0];
        be       = is_word ? 4'hf : is_byte ? 4'b0001 << addr[1:0] : addr[1] ? 4'hc : 4'h3;
        wd       = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
        hs       = state == REQ && m_ready;
        // progress in the final allowed cycle beats the timeout
        tmo      = cnt == CW'(TIMEOUT - 1) && ((state == REQ && !hs) || (state == WAIT && !m_rvalid));
        rbyte    = m_rdata[8*k_r +: 8];
        rhalf    = k_r[1] ? m_rdata[31:16] : m_rdata[15:0];
        ext      = op_r == 3'd5 ? {{24{rbyte[7]}}, rbyte} :
                   op_r == 3'd6 ? {{16{rhalf[15]}}, rhalf} : m_rdata;
        stall    = reset && (accept || state == REQ || state == WAIT);
        state_n  = state;
        case (state)
            IDLE:    state_n = accept ? (misal ? DONE : REQ) : IDLE;
            REQ:     state_n = hs ? (m_we ? DONE : WAIT) : tmo ? DONE : REQ;
            WAIT:    state_n = (m_rvalid || tmo) ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_r    <= '0;
            k_r     <= '0;
            done    <= 1'b0;
            rdata   <= '0;
            adel    <= 1'b0;
            ades    <= 1'b0;
            bus_err <= 1'b0;
            m_valid <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_be    <= '0;
            m_wdata <= '0;
        end else begin
            state   <= state_n;
            cnt     <= accept ? '0 : (state == REQ || state == WAIT) ? cnt + 1'b1 : cnt;
            done    <= state_n == DONE;
            adel    <= accept && misal && is_load;
            ades    <= accept && misal && is_store;
            bus_err <= tmo;
            m_valid <= state_n == REQ;
            if (accept) begin
                op_r    <= dm_op;
                k_r     <= addr[1:0];
                m_we    <= is_store;
                m_addr  <= {addr[31:2], 2'b00};
                m_be    <= be;
                m_wdata <= wd;
                rdata   <= '0;
            end else if (state == WAIT && m_rvalid) begin
                rdata <= ext;
            end
        end
    end
endmodule

// File: tb/tb_dm_master.sv
// tb_dm_master: directed scoreboard bench for dm_master (TIMEOUT=8).
module tb_dm_master;
    logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, m_ready = 1'b0, m_rvalid = 1'b0;
    logic [2:0]  dm_op = '0;
    logic [31:0] addr = '0, wdata = '0, m_rdata = '0;
    logic        stall, done, adel, ades, bus_err, m_valid, m_we;
    logic [31:0] rdata, m_addr, m_wdata;
    logic [3:0]  m_be;
    int vectors = 0, miscompares = 0;
    typedef struct {
        logic [31:0] rdata;
        logic        adel, ades, berr;
        int          cycles;
    } exp_t;
    exp_t sb[$];

    dm_master #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .dm_op(dm_op), .addr(addr),
        .wdata(wdata), .stall(stall), .done(done), .rdata(rdata), .adel(adel), .ades(ades),
        .bus_err(bus_err), .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
        .m_be(m_be), .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left just after a rising edge with the DUT in IDLE.
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int rdy_dly, input int rv_dly, input bit bus,
                       input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                       input logic [31:0] e_rdata, input bit e_adel, input bit e_ades,
                       input bit e_berr, input int e_cyc);
        exp_t e, got;
        int vcnt = 0, hs_cyc = 0;
        bit fin = 0;
        bit e_we = op < 3'd4;
        e.rdata = e_rdata; e.adel = e_adel; e.ades = e_ades; e.berr = e_berr; e.cycles = e_cyc;
        sb.push_back(e);
        req_valid = 1'b1; dm_op = op; addr = a; wdata = wd; m_rdata = rd;
        for (int c = 1; c <= e_cyc + 8 && !fin; c++) begin
            m_ready  = m_valid && vcnt >= rdy_dly;
            m_rvalid = rv_dly > 0 && hs_cyc > 0 && c >= hs_cyc + rv_dly;
            @(negedge clk);
            if (m_valid) begin
                vcnt++;
                check("m_addr", m_addr, e_addr);
                check("m_be", 32'(m_be), 32'(e_be));
                check("m_we", 32'(m_we), 32'(e_we));
                if (e_we) check("m_wdata", m_wdata, e_wd);
                if (m_ready) hs_cyc = c;
            end
            if (!bus) check("no_req", 32'(m_valid), 32'd0);
            if (done) begin
                got = sb.pop_front();
                check("stall_done", 32'(stall), 32'd0);
                check("rdata", rdata, got.rdata);
                check("adel", 32'(adel), 32'(got.adel));
                check("ades", 32'(ades), 32'(got.ades));
                check("bus_err", 32'(bus_err), 32'(got.berr));
                check("latency", c, got.cycles);
                fin = 1;
                req_valid = 1'b0;
            end else begin
                check("stall", 32'(stall), 32'd1);
                check("flags_off", {29'd0, adel, ades, bus_err}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (!fin) begin
            check("done_seen", 32'(fin), 32'd1);
            got = sb.pop_front();
        end
        m_ready = 1'b0; m_rvalid = 1'b0; req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_m_be", 32'(m_be), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        //   op     addr         wdata         m_rdata       rdy rv bus  m_addr        be       m_wdata       rdata       adel ades berr cyc
        run(3'd2, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 0, 1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0,        0, 0, 0, 3);
        run(3'd6, 32'h0000_2002, 32'h0,         32'h8123_4567, 0, 1, 1, 32'h0000_2000, 4'b1100, 32'h0,        32'hFFFF_8123, 0, 0, 0, 4);
        run(3'd6, 32'h0000_2000, 32'h0,         32'h8123_4567, 0, 1, 1, 32'h0000_2000, 4'b0011, 32'h0,        32'h0000_4567, 0, 0, 0, 4);
        run(3'd4, 32'h0000_3004, 32'h0,         32'hDEAD_BEEF, 5, 1, 1, 32'h0000_3004, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 9);
        run(3'd4, 32'h0000_2001, 32'h0,         32'h0,         0, 1, 0, 32'h0000_2000, 4'b1111, 32'h0,        32'h0,         1, 0, 0, 2);
        run(3'd3, 32'h0000_2003, 32'h1234_5678, 32'h0,         0, 0, 0, 32'h0000_2000, 4'b1100, 32'h5678_5678, 32'h0,        0, 1, 0, 2);
        run(3'd5, 32'h0000_5001, 32'h0,         32'h1234_80FF, 0, 2, 1, 32'h0000_5000, 4'b0010, 32'h0,        32'hFFFF_FF80, 0, 0, 0, 5);
        run(3'd1, 32'h0000_0040, 32'h1234_5678, 32'h0,         0, 0, 1, 32'h0000_0040, 4'b1111, 32'h1234_5678, 32'h0,        0, 0, 0, 3);
        run(3'd3, 32'h0000_0042, 32'hCAFE_BEEF, 32'h0,         2, 0, 1, 32'h0000_0040, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0, 0, 5);
        run(3'd5, 32'h0000_6000, 32'h0,         32'h0000_007F, 0, 0, 1, 32'h0000_6000, 4'b0001, 32'h0,        32'h0,         0, 0, 1, 10);
        m_rdata = 32'hFFFF_FFFF;
        m_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_done", 32'(done), 32'd0);
            check("late_bus_err", 32'(bus_err), 32'd0);
            check("late_rdata", rdata, 32'd0);
            check("late_stall", 32'(stall), 32'd0);
        end
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        req_valid = 1'b1; dm_op = 3'd4; addr = 32'h0000_7004;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("req_m_valid", 32'(m_valid), 32'd1);
        check("req_stall", 32'(stall), 32'd1);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_req_m_valid", 32'(m_valid), 32'd0);
        check("rst_req_stall", 32'(stall), 32'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; dm_op = 3'd4; addr = 32'h0000_7008; m_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("wait_stall", 32'(stall), 32'd1);
        check("wait_m_valid", 32'(m_valid), 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_wait_stall", 32'(stall), 32'd0);
        check("rst_wait_m_valid", 32'(m_valid), 32'd0);
        check("rst_wait_done", 32'(done), 32'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        run(3'd1, 32'h0000_7010, 32'h0BAD_F00D, 32'h0,         0, 0, 1, 32'h0000_7010, 4'b1111, 32'h0BAD_F00D, 32'h0,        0, 0, 0, 3);
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
